// File: rtl/lfsr_prn.sv
// Purpose: two independent maximal-length Fibonacci LFSRs, a 10-bit address and a 32-bit data generator.
// Latency: one cycle; an enable sampled high at a rising edge shows the advanced state after that edge.
// Backpressure: none; each enable only gates its own register, and a low enable holds the current state.
// Optional feature: define LFSR_LOCKUP_RECOVER_EN to build zero detectors that force a stuck register back to 1.
module lfsr_prn #(
  parameter logic [9:0]  ADDR_SEED = 10'h001,
  parameter logic [31:0] DATA_SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_addr,
  input  logic        en_data,
  output logic [9:0]  lfsr_addr,
  output logic [31:0] lfsr_data
);

  // Value loaded by the lock-up recovery path. It is the smallest nonzero state.
  localparam logic [9:0]  ADDR_ONE = 10'h001;
  localparam logic [31:0] DATA_ONE = 32'h0000_0001;

  logic [9:0]  addr_q;
  logic [9:0]  addr_nxt;
  logic [31:0] data_q;
  logic [31:0] data_nxt;
  logic        fb_a;
  logic        fb_d;

  // Feedback taps: x^10+x^7+1 on the address LFSR, x^32+x^22+x^2+x^1+1 on the data LFSR.
  always_comb begin
    fb_a = addr_q[9] ^ addr_q[6];
    fb_d = data_q[31] ^ data_q[21] ^ data_q[1] ^ data_q[0];
  end

  // Next-state selection for the address LFSR: shift left when enabled, otherwise hold.
  always_comb begin
    addr_nxt = addr_q;
    if (en_addr) begin
      addr_nxt = {addr_q[8:0], fb_a};
    end
`ifdef LFSR_LOCKUP_RECOVER_EN
    // A zero state can never leave on its own, so it overrides the enable.
    if (addr_q == 10'h000) begin
      addr_nxt = ADDR_ONE;
    end
`endif
  end

  // Next-state selection for the data LFSR: shift left when enabled, otherwise hold.
  always_comb begin
    data_nxt = data_q;
    if (en_data) begin
      data_nxt = {data_q[30:0], fb_d};
    end
`ifdef LFSR_LOCKUP_RECOVER_EN
    // A zero state can never leave on its own, so it overrides the enable.
    if (data_q == 32'h0000_0000) begin
      data_nxt = DATA_ONE;
    end
`endif
  end

  // Address state register; reset loads the seed without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= ADDR_SEED;
    end else begin
      addr_q <= addr_nxt;
    end
  end

  // Data state register; reset loads the seed without waiting for a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= DATA_SEED;
    end else begin
      data_q <= data_nxt;
    end
  end

  // Outputs are the raw register contents.
  always_comb begin
    lfsr_addr = addr_q;
    lfsr_data = data_q;
  end

endmodule

// File: tb/tb_lfsr_prn.sv
// Purpose: directed self-checking bench for lfsr_prn, default seeds plus a zero-seed instance.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: not applicable; enables are driven directly from the stimulus.
module tb_lfsr_prn;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_addr = 1'b0;
  logic        en_data = 1'b0;
  logic [9:0]  lfsr_addr;
  logic [31:0] lfsr_data;

  logic        rst_z = 1'b0;
  logic        en_addr_z = 1'b0;
  logic        en_data_z = 1'b0;
  logic [9:0]  lfsr_addr_z;
  logic [31:0] lfsr_data_z;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lfsr_prn dut (
    .clk       (clk),
    .rst       (rst),
    .en_addr   (en_addr),
    .en_data   (en_data),
    .lfsr_addr (lfsr_addr),
    .lfsr_data (lfsr_data)
  );

  lfsr_prn #(
    .ADDR_SEED (10'h000),
    .DATA_SEED (32'h0000_0000)
  ) dut_zero (
    .clk       (clk),
    .rst       (rst_z),
    .en_addr   (en_addr_z),
    .en_data   (en_data_z),
    .lfsr_addr (lfsr_addr_z),
    .lfsr_data (lfsr_data_z)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [9:0]  addr_exp [10];
  logic [31:0] data_exp [3];
  logic        seen [1024];
  int          hits_3ff;
  int          repeats;
  int          early_wrap;
  logic [9:0]  v;
  logic [9:0]  exp_zero_addr;
  logic [31:0] exp_zero_data;

  initial begin
    addr_exp = '{10'h002, 10'h004, 10'h008, 10'h010, 10'h020,
                 10'h040, 10'h081, 10'h102, 10'h204, 10'h009};
    data_exp = '{32'h0000_0003, 32'h0000_0006, 32'h0000_000D};

    // Reset held for 3 cycles while enables toggle.
    for (int i = 0; i < 3; i++) begin
      en_addr = i[0];
      en_data = ~i[0];
      tick();
      check("rst_addr", {22'd0, lfsr_addr}, 32'h0000_0001);
      check("rst_data", lfsr_data, 32'h0000_0001);
    end

    // Release and step the address LFSR alone.
    rst = 1'b1;
    en_addr = 1'b1;
    en_data = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("addr_seq", {22'd0, lfsr_addr}, {22'd0, addr_exp[i]});
      check("addr_seq_data_hold", lfsr_data, 32'h0000_0001);
    end

    // Step the data LFSR alone.
    en_addr = 1'b0;
    en_data = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("data_seq", lfsr_data, data_exp[i]);
      check("data_seq_addr_hold", {22'd0, lfsr_addr}, 32'h0000_0009);
    end

    // Neither enable: both hold.
    en_data = 1'b0;
    tick();
    check("idle_addr", {22'd0, lfsr_addr}, 32'h0000_0009);
    check("idle_data", lfsr_data, 32'h0000_000D);

    // Restart from seed, then walk one full address period.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 1024; i++) seen[i] = 1'b0;
    seen[1] = 1'b1;
    hits_3ff = 0;
    repeats = 0;
    early_wrap = 0;
    en_addr = 1'b1;
    for (int i = 1; i <= 1023; i++) begin
      tick();
      v = lfsr_addr;
      if (v == 10'h3FF) hits_3ff++;
      if (i < 1023) begin
        if (seen[v]) repeats++;
        if (v == 10'h001) early_wrap++;
        seen[v] = 1'b1;
      end
    end
    check("period_wrap", {22'd0, lfsr_addr}, 32'h0000_0001);
    check("period_3ff_once", hits_3ff, 32'd1);
    check("period_no_repeat", repeats, 32'd0);
    check("period_no_early_wrap", early_wrap, 32'd0);
    check("period_data_hold", lfsr_data, 32'h0000_0001);

    // Advance both 5 steps, then an asynchronous reset pulse mid-cycle.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    en_addr = 1'b1;
    en_data = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("both5_addr", {22'd0, lfsr_addr}, 32'h0000_0020);
    check("both5_data", lfsr_data, 32'h0000_0036);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_rst_addr", {22'd0, lfsr_addr}, 32'h0000_0001);
    check("async_rst_data", lfsr_data, 32'h0000_0001);
    #2;
    rst = 1'b1;
    tick();
    check("restart_addr", {22'd0, lfsr_addr}, 32'h0000_0002);
    check("restart_data", lfsr_data, 32'h0000_0003);

    // Zero-seed instance: lock-up behaviour depends on the build.
`ifdef LFSR_LOCKUP_RECOVER_EN
    exp_zero_addr = 10'h001;
    exp_zero_data = 32'h0000_0001;
`else
    exp_zero_addr = 10'h000;
    exp_zero_data = 32'h0000_0000;
`endif
    rst_z = 1'b1;
    en_addr_z = 1'b0;
    en_data_z = 1'b0;
    #1;
    check("zero_release_addr", {22'd0, lfsr_addr_z}, 32'h0000_0000);
    check("zero_release_data", lfsr_data_z, 32'h0000_0000);
    tick();
    check("zero_edge1_addr", {22'd0, lfsr_addr_z}, {22'd0, exp_zero_addr});
    check("zero_edge1_data", lfsr_data_z, exp_zero_data);
    tick();
    check("zero_edge2_addr", {22'd0, lfsr_addr_z}, {22'd0, exp_zero_addr});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
